// File: rtl/gate_sweep_ctrl.sv
// Clocked self-checking sweep of the BUF/XNOR/NAND gate unit.
// Optional first-mismatch capture ports: GATE_SWEEP_FAIL_CAPTURE_EN.
module gate_sweep_ctrl #(
   parameter int SETTLE = 2,
   parameter int ERRW   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            z1,
   input  logic            z2,
   input  logic            z3,
   output logic            x1,
   output logic            x2,
   output logic            x3,
   output logic            y2,
   output logic            y3,
   output logic [1:0]      gate_sel,
   output logic [1:0]      vec_idx,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ERRW-1:0] err_count
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
   ,
   output logic            fail_valid,
   output logic [1:0]      fail_gate,
   output logic [1:0]      fail_vec
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [ERRW-1:0] ERR_MAX     = '1;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [1:0]      gate_q, gate_d;
   logic [1:0]      vec_q, vec_d;
   logic [4:0]      drv_q, drv_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [ERRW-1:0] err_q, err_d;
   logic            fv_q, fv_d;
   logic [1:0]      fg_q, fg_d;
   logic [1:0]      fvec_q, fvec_d;

   logic            expect_z;
   logic            got_z;
   logic            mismatch;
   logic            last_vec;

   // drv_q bit order: {x1, x2, y2, x3, y3}
   always_comb begin
      expect_z = 1'b0;
      got_z    = 1'b0;
      case (gate_q)
         2'd0: begin
            expect_z = drv_q[4];
            got_z    = z1;
         end
         2'd1: begin
            expect_z = ~(drv_q[3] ^ drv_q[2]);
            got_z    = z2;
         end
         2'd2: begin
            expect_z = ~(drv_q[1] & drv_q[0]);
            got_z    = z3;
         end
         default: begin
            expect_z = 1'b0;
            got_z    = 1'b0;
         end
      endcase
   end

   assign mismatch = got_z != expect_z;
   assign last_vec = (gate_q == 2'd2) && (vec_q == 2'd3);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gate_d  = gate_q;
      vec_d   = vec_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fg_d    = fg_q;
      fvec_d  = fvec_q;
      drv_d   = 5'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               cnt_d   = 4'd0;
               gate_d  = 2'd0;
               vec_d   = 2'd0;
               busy_d  = 1'b1;
               pass_d  = 1'b0;
               err_d   = '0;
               fv_d    = 1'b0;
               fg_d    = 2'd0;
               fvec_d  = 2'd0;
            end
         end
         S_SETTLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_SAMPLE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (mismatch) begin
                  if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                  if (!fv_q) begin
                     fv_d   = 1'b1;
                     fg_d   = gate_q;
                     fvec_d = vec_q;
                  end
               end
               if (last_vec) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  pass_d  = (err_d == '0);
                  gate_d  = 2'd0;
                  vec_d   = 2'd0;
               end else begin
                  state_d = S_SETTLE;
                  cnt_d   = 4'd0;
                  if (gate_q == 2'd0 && vec_q == 2'd1) begin
                     gate_d = 2'd1;
                     vec_d  = 2'd0;
                  end else if (vec_q == 2'd3) begin
                     gate_d = gate_q + 2'd1;
                     vec_d  = 2'd0;
                  end else begin
                     vec_d = vec_q + 2'd1;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // abort leaves everything idle except the frozen error state
      if (state_d == S_IDLE && state_q != S_IDLE && state_q != S_DONE) begin
         busy_d = 1'b0;
         pass_d = 1'b0;
         gate_d = 2'd0;
         vec_d  = 2'd0;
      end

      if (state_d == S_SETTLE || state_d == S_SAMPLE) begin
         case (gate_d)
            2'd0:    drv_d = {vec_d[0], 4'b0};
            2'd1:    drv_d = {1'b0, vec_d[0], vec_d[1], 2'b0};
            2'd2:    drv_d = {3'b0, vec_d[0], vec_d[1]};
            default: drv_d = 5'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         gate_q  <= 2'd0;
         vec_q   <= 2'd0;
         drv_q   <= 5'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fg_q    <= 2'd0;
         fvec_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gate_q  <= gate_d;
         vec_q   <= vec_d;
         drv_q   <= drv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fg_q    <= fg_d;
         fvec_q  <= fvec_d;
      end
   end

   assign x1        = drv_q[4];
   assign x2        = drv_q[3];
   assign y2        = drv_q[2];
   assign x3        = drv_q[1];
   assign y3        = drv_q[0];
   assign gate_sel  = gate_q;
   assign vec_idx   = vec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;

`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
   assign fail_valid = fv_q;
   assign fail_gate  = fg_q;
   assign fail_vec   = fvec_q;
`else
   logic unused_fail;
   assign unused_fail = fv_q ^ (^fg_q) ^ (^fvec_q);
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized sweep bench for gate_sweep_ctrl against a vector-list model.
// Checks fail-capture ports when GATE_SWEEP_FAIL_CAPTURE_EN is defined.
module tb_gate_sweep_ctrl;

   localparam int SETTLE = 2;
   localparam int HOLD   = SETTLE + 1;
   localparam int NVEC   = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic z1, z2, z3;
   logic [1:0] f1 = 2'd0, f2 = 2'd0, f3 = 2'd0;

   logic x1, x2, x3, y2, y3, busy, done, pass;
   logic [1:0] gate_sel, vec_idx;
   logic [3:0] err_count;
   logic bx1, bx2, bx3, by2, by3, bbusy, bdone, bpass;
   logic [1:0] bgate_sel, bvec_idx;
   logic [1:0] berr_count;
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
   logic fail_valid, bfail_valid;
   logic [1:0] fail_gate, fail_vec, bfail_gate, bfail_vec;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   gate_sweep_ctrl #(.SETTLE(SETTLE), .ERRW(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .z1(z1), .z2(z2), .z3(z3),
      .x1(x1), .x2(x2), .x3(x3), .y2(y2), .y3(y3),
      .gate_sel(gate_sel), .vec_idx(vec_idx),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
      , .fail_valid(fail_valid), .fail_gate(fail_gate), .fail_vec(fail_vec)
`endif
   );

   gate_sweep_ctrl #(.SETTLE(SETTLE), .ERRW(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .z1(z1), .z2(z2), .z3(z3),
      .x1(bx1), .x2(bx2), .x3(bx3), .y2(by2), .y3(by3),
      .gate_sel(bgate_sel), .vec_idx(bvec_idx),
      .busy(bbusy), .done(bdone), .pass(bpass), .err_count(berr_count)
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
      , .fail_valid(bfail_valid), .fail_gate(bfail_gate), .fail_vec(bfail_vec)
`endif
   );

   // fault code: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
   function automatic logic fault(input logic [1:0] f, input logic v);
      case (f)
         2'd1:    return 1'b0;
         2'd2:    return 1'b1;
         2'd3:    return ~v;
         default: return v;
      endcase
   endfunction

   always_comb begin
      z1 = fault(f1, x1);
      z2 = fault(f2, ~(x2 ^ y2));
      z3 = fault(f3, ~(x3 & y3));
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void vec_of(input int k, output int g, output int v);
      if (k < 2) begin g = 0; v = k; end
      else if (k < 6) begin g = 1; v = k - 2; end
      else begin g = 2; v = k - 6; end
   endfunction

   // {busy, done, gate_sel, vec_idx, x1, x2, y2, x3, y3}
   function automatic logic [10:0] exp_fp(input int k);
      int g, v;
      logic [4:0] d;
      vec_of(k, g, v);
      d = 5'b0;
      if (g == 0) d[4] = v[0];
      if (g == 1) begin d[3] = v[0]; d[2] = v[1]; end
      if (g == 2) begin d[1] = v[0]; d[0] = v[1]; end
      return {1'b1, 1'b0, 2'(g), 2'(v), d};
   endfunction

   function automatic logic [10:0] fp_a();
      return {busy, done, gate_sel, vec_idx, x1, x2, y2, x3, y3};
   endfunction

   function automatic logic [10:0] fp_b();
      return {bbusy, bdone, bgate_sel, bvec_idx, bx1, bx2, by2, bx3, by3};
   endfunction

   // mismatches among vectors whose sample edge is at or before `upto`
   task automatic model(input int upto, output int cnt, output int fg,
                        output int fv, output bit any);
      int g, v;
      logic xa, ya, ideal, seen;
      cnt = 0; fg = 0; fv = 0; any = 0;
      for (int k = 0; k < NVEC; k++) begin
         if (HOLD * (k + 1) <= upto) begin
            vec_of(k, g, v);
            xa = v[0];
            ya = v[1];
            if (g == 0) begin ideal = xa; seen = fault(f1, ideal); end
            else if (g == 1) begin ideal = ~(xa ^ ya); seen = fault(f2, ideal); end
            else begin ideal = ~(xa & ya); seen = fault(f3, ideal); end
            if (seen != ideal) begin
               if (!any) begin fg = g; fv = v; any = 1; end
               cnt++;
            end
         end
      end
   endtask

   task automatic chk_result(input string tag, input int cnt, input logic p,
                             input int fg, input int fv, input bit any);
      chk({tag, "_err"}, 32'(err_count), (cnt > 15) ? 15 : cnt);
      chk({tag, "_err2"}, 32'(berr_count), (cnt > 3) ? 3 : cnt);
      chk({tag, "_pass"}, 32'(pass), 32'(p));
      chk({tag, "_pass2"}, 32'(bpass), 32'(p));
`ifdef GATE_SWEEP_FAIL_CAPTURE_EN
      chk({tag, "_fv"}, 32'(fail_valid), 32'(any));
      chk({tag, "_fgv"}, {28'd0, fail_gate, fail_vec},
          any ? 32'((fg << 2) | fv) : 32'd0);
      chk({tag, "_fv2"}, 32'(bfail_valid), 32'(any));
`else
      if (any && fg > 3 && fv > 3) chk({tag, "_fgv"}, 32'(fg), 32'(fv));
`endif
   endtask

   task automatic sweep(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input int abort_t,
                        input int rst_t, input int noise_t);
      int cnt, fg, fv;
      bit any;
      f1 = a; f2 = b; f3 = c;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 32; t++) begin
         if (t < HOLD * NVEC) begin
            chk("drv", 32'(fp_a()), 32'(exp_fp(t / HOLD)));
            chk("drv2", 32'(fp_b()), 32'(exp_fp(t / HOLD)));
         end else if (t == HOLD * NVEC) begin
            model(HOLD * NVEC, cnt, fg, fv, any);
            chk("done_fp", 32'(fp_a()), 32'h200);
            chk("done_fp2", 32'(fp_b()), 32'h200);
            chk_result("done", cnt, cnt == 0, fg, fv, any);
         end else begin
            chk("idle_fp", 32'(fp_a()), 32'h000);
            chk_result("hold", cnt, cnt == 0, fg, fv, any);
         end
         start = (t == noise_t);
         abort = (t == abort_t);
         rst   = (t == rst_t);
         @(negedge clk);
         start = 1'b0;
         if (t == abort_t) begin
            abort = 1'b0;
            model(t, cnt, fg, fv, any);
            chk("abort_fp", 32'(fp_a()), 32'h000);
            chk("abort_fp2", 32'(fp_b()), 32'h000);
            chk_result("abort", cnt, 1'b0, fg, fv, any);
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               chk("abort_quiet", 32'({busy, done, bbusy, bdone}), 32'd0);
            end
            return;
         end
         if (t == rst_t) begin
            rst = 1'b0;
            chk("rst_fp", 32'(fp_a()), 32'h000);
            chk("rst_fp2", 32'(fp_b()), 32'h000);
            chk_result("rst", 0, 1'b0, 0, 0, 0);
            return;
         end
      end
   endtask

   initial begin
      int ab, rs, nz;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_fp", 32'(fp_a()), 32'h000);
      chk("reset_fp2", 32'(fp_b()), 32'h000);
      chk_result("reset", 0, 1'b0, 0, 0, 0);
      rst = 1'b0;

      sweep(2'd0, 2'd0, 2'd0, -1, -1, 7);
      sweep(2'd0, 2'd0, 2'd1, -1, -1, -1);
      sweep(2'd2, 2'd3, 2'd0, -1, -1, -1);
      sweep(2'd3, 2'd3, 2'd3, -1, -1, 20);
      sweep(2'd0, 2'd0, 2'd0, 4 * HOLD + 1, -1, -1);
      sweep(2'd0, 2'd0, 2'd0, -1, -1, -1);
      sweep(2'd1, 2'd3, 2'd2, -1, 7 * HOLD + 1, 5);
      sweep(2'd3, 2'd0, 2'd0, -1, -1, -1);

      for (int n = 0; n < 16; n++) begin
         ab = -1; rs = -1; nz = -1;
         if ($urandom_range(5, 0) == 0) ab = $urandom_range(HOLD * NVEC - 1, 0);
         else if ($urandom_range(7, 0) == 0) rs = $urandom_range(HOLD * NVEC - 1, 0);
         if ($urandom_range(1, 0) == 1) nz = $urandom_range(HOLD * NVEC - 1, 0);
         sweep(2'($urandom), 2'($urandom), 2'($urandom), ab, rs, nz);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
